// File: rtl/rep_seq_monitor_pkg.sv
// Shared types and constants for the a[*LO:HI] ##DLY b run-time sequence checker.
package rep_seq_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  localparam int OFS_W = 5;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating increment used by both outcome counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
    return (en && value != CNT_MAX) ? value + CNT_W'(1) : value;
  endfunction

endpackage

// File: rtl/seq_pending_sreg.sv
// Candidate end-point vector: bit j means "a candidate is due j offsets from now".
// New candidates are merged combinationally so DLY == 0 ones are visible in the same cycle.
module seq_pending_sreg #(
  parameter int W   = 5,
  parameter int DLY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  input  logic set_main,
  input  logic set_empty,
  output logic head,
  output logic pending
);

  localparam bit HAS_EMPTY = (DLY > 0);
  localparam int EMPTY_POS = HAS_EMPTY ? DLY - 1 : 0;

  logic [W-1:0] p;
  logic [W-1:0] cand;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    cand = p;
    if (set_main) cand[DLY] = 1'b1;
    if (set_empty && HAS_EMPTY) cand[EMPTY_POS] = 1'b1;
    head    = cand[0];
    pending = |(cand >> 1);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) p <= '0;
    else       p <= advance ? (cand >> 1) : '0;
  end

endmodule

// File: rtl/rep_seq_monitor.sv
// Run-time checker for a[*LO:HI] ##DLY b with registered match/fail/drop pulses
// and saturating outcome counters; one attempt at a time.
module rep_seq_monitor
  import rep_seq_monitor_pkg::*;
#(
  parameter int LO  = 0,
  parameter int HI  = 4,
  parameter int DLY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             match,
  output logic             fail,
  output logic             drop,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam int PW = HI + DLY;

  seq_state_t       state, state_next;
  logic [OFS_W-1:0] ofs, cur_ofs;
  logic             run;
  logic             accept, eval, run_now, set_main, set_empty;
  logic             head, pending, hit, dead, advance;

  seq_pending_sreg #(
    .W  (PW),
    .DLY(DLY)
  ) u_pending (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .set_main (set_main),
    .set_empty(set_empty),
    .head     (head),
    .pending  (pending)
  );

  // Offset 0 of an accepted start is evaluated in the start cycle itself.
  always_comb begin
    accept    = start && (state != RUN);
    eval      = accept || (state == RUN);
    cur_ofs   = accept ? '0 : ofs;
    run_now   = eval && (accept || run) && a && (cur_ofs < OFS_W'(HI));
    set_main  = run_now && (int'(cur_ofs) + 1 >= LO);
    set_empty = accept && (LO == 0) && (DLY >= 1);
    hit       = eval && head && b;
    dead      = eval && !hit && !run_now && !pending;
    advance   = eval && !hit && !dead;

    state_next = IDLE;
    case (state)
      RUN:     state_next = advance ? RUN : DONE;
      default: if (accept) state_next = advance ? RUN : DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ofs         <= '0;
      run         <= 1'b0;
      match       <= 1'b0;
      fail        <= 1'b0;
      drop        <= 1'b0;
      match_count <= '0;
      fail_count  <= '0;
    end else begin
      state       <= state_next;
      ofs         <= cur_ofs + OFS_W'(1);
      run         <= run_now;
      match       <= hit;
      fail        <= dead;
      drop        <= start && (state == RUN);
      match_count <= sat_inc(match_count, hit);
      fail_count  <= sat_inc(fail_count, dead);
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_rep_seq_monitor.sv
// Self-checking bench: four parameterisations driven by shared stimulus, each checked
// against a history-based model of a[*LO:HI] ##DLY b.
module tb_rep_seq_monitor;

  localparam int N = 4;
  localparam int LO_C  [N] = '{0, 0, 2, 1};
  localparam int HI_C  [N] = '{1, 2, 4, 3};
  localparam int DLY_C [N] = '{0, 1, 1, 0};

  logic clk = 1'b0;
  logic reset, start, a, b;
  logic        busy_o [N];
  logic        match_o[N];
  logic        fail_o [N];
  logic        drop_o [N];
  logic [15:0] mc_o   [N];
  logic [15:0] fc_o   [N];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rep_seq_monitor #(.LO(LO_C[0]), .HI(HI_C[0]), .DLY(DLY_C[0])) u0 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_o[0]), .match(match_o[0]), .fail(fail_o[0]), .drop(drop_o[0]),
    .match_count(mc_o[0]), .fail_count(fc_o[0]));
  rep_seq_monitor #(.LO(LO_C[1]), .HI(HI_C[1]), .DLY(DLY_C[1])) u1 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_o[1]), .match(match_o[1]), .fail(fail_o[1]), .drop(drop_o[1]),
    .match_count(mc_o[1]), .fail_count(fc_o[1]));
  rep_seq_monitor #(.LO(LO_C[2]), .HI(HI_C[2]), .DLY(DLY_C[2])) u2 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_o[2]), .match(match_o[2]), .fail(fail_o[2]), .drop(drop_o[2]),
    .match_count(mc_o[2]), .fail_count(fc_o[2]));
  rep_seq_monitor #(.LO(LO_C[3]), .HI(HI_C[3]), .DLY(DLY_C[3])) u3 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_o[3]), .match(match_o[3]), .fail(fail_o[3]), .drop(drop_o[3]),
    .match_count(mc_o[3]), .fail_count(fc_o[3]));

  // Reference model state: the a/b history of the live attempt, indexed by offset.
  bit live [N];
  int t    [N];
  bit ah   [N][32];
  bit bh   [N][32];
  bit e_busy[N], e_match[N], e_fail[N], e_drop[N];
  int e_mc[N], e_fc[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // 0: undecided, 1: match, 2: fail at offset t[i].
  function automatic int decide(int i);
    int lo = LO_C[i], hi = HI_C[i], dly = DLY_C[i], tt = t[i];
    int lead = 0, kmin, k;
    bit m = 0, later = 0, broken;
    while (lead <= tt && ah[i][lead]) lead++;
    kmin = (lo < 1) ? 1 : lo;
    // A repetition of length k ends at offset k-1; b is due at k-1+dly.
    k = tt - dly + 1;
    if (bh[i][tt]) begin
      if (lo == 0 && dly >= 1 && tt == dly - 1) m = 1;
      if (k >= kmin && k <= hi && k <= lead) m = 1;
    end
    if (m) return 1;
    broken = (lead <= tt) || (tt >= hi);
    if (lo == 0 && dly >= 1 && dly - 1 > tt) later = 1;
    for (int kk = kmin; kk <= hi; kk++)
      if (kk <= lead && kk - 1 + dly > tt) later = 1;
    return (broken && !later) ? 2 : 0;
  endfunction

  function automatic int sat(int v, bit en);
    return (en && v < 16'hFFFF) ? v + 1 : v;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit av, input bit bv);
    int d;
    for (int i = 0; i < N; i++) begin
      e_match[i] = 0;
      e_fail[i]  = 0;
      if (r) begin
        live[i] = 0; e_drop[i] = 0; e_mc[i] = 0; e_fc[i] = 0;
      end else begin
        e_drop[i] = s && live[i];
        if (s && !live[i]) begin
          live[i] = 1;
          t[i] = 0;
        end
        if (live[i]) begin
          ah[i][t[i]] = av;
          bh[i][t[i]] = bv;
          d = decide(i);
          if (d == 1) begin
            e_match[i] = 1; live[i] = 0; e_mc[i] = sat(e_mc[i], 1'b1);
          end else if (d == 2) begin
            e_fail[i] = 1; live[i] = 0; e_fc[i] = sat(e_fc[i], 1'b1);
          end else begin
            t[i]++;
          end
        end
      end
      e_busy[i] = live[i];
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every instance to the model.
  task automatic step(input bit r, input bit s, input bit av, input bit bv);
    reset = r; start = s; a = av; b = bv;
    model_step(r, s, av, bv);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("busy%0d", i),  32'(busy_o[i]),  32'(e_busy[i]));
      check($sformatf("match%0d", i), 32'(match_o[i]), 32'(e_match[i]));
      check($sformatf("fail%0d", i),  32'(fail_o[i]),  32'(e_fail[i]));
      check($sformatf("drop%0d", i),  32'(drop_o[i]),  32'(e_drop[i]));
      check($sformatf("mcount%0d", i), 32'(mc_o[i]), 32'(e_mc[i]));
      check($sformatf("fcount%0d", i), 32'(fc_o[i]), 32'(e_fc[i]));
      check($sformatf("excl%0d", i), 32'(match_o[i] & fail_o[i]), 32'd0);
    end
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      check("rst_busy", 32'(busy_o[i]), 32'd0);
      check("rst_mcount", 32'(mc_o[i]), 32'd0);
    end

    // LO=0 HI=1 DLY=0: a&b at offset 0 matches; a low fails; empty term never matches.
    step(0, 1, 1, 1);
    check("c0_match", 32'(match_o[0]), 32'd1);
    check("c0_busy_low", 32'(busy_o[0]), 32'd0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    check("c0_empty_fail", 32'(fail_o[0]), 32'd1);
    check("c0_empty_nomatch", 32'(match_o[0]), 32'd0);
    // LO=0 HI=2 DLY=1: empty term gives ##0 b.
    check("c1_empty_match", 32'(match_o[1]), 32'd1);

    // LO=2 HI=4 DLY=1: a at offsets 0..2, b at offset 3.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    check("c2_busy_rise", 32'(busy_o[2]), 32'd1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("c2_wait", 32'(match_o[2]), 32'd0);
    step(0, 0, 0, 1);
    check("c2_match", 32'(match_o[2]), 32'd1);
    check("c2_mcount", 32'(mc_o[2]), 32'd1);
    step(0, 0, 0, 0);

    // Same config, b never high: decided at offset 4.
    step(0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    check("c2_fail_early", 32'(fail_o[2]), 32'd0);
    step(0, 0, 1, 0);
    check("c2_fail", 32'(fail_o[2]), 32'd1);
    check("c2_fcount", 32'(fc_o[2]), 32'd1);

    // Overlapping start is dropped and does not count.
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    check("c2_drop", 32'(drop_o[2]), 32'd1);
    step(0, 0, 1, 0);
    check("c2_drop_pulse", 32'(drop_o[2]), 32'd0);
    step(0, 0, 0, 1);
    check("c2_ovl_match", 32'(match_o[2]), 32'd1);
    check("c2_ovl_mcount", 32'(mc_o[2]), 32'd2);

    // Reset at offset 2 abandons the attempt silently.
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    check("rst_mid_busy", 32'(busy_o[2]), 32'd0);
    check("rst_mid_fail", 32'(fail_o[2]), 32'd0);
    check("rst_mid_fcount", 32'(fc_o[2]), 32'd0);
    step(0, 0, 0, 0);
    check("rst_mid_nofail", 32'(fail_o[2]), 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

    // Saturation: preload match_count, then three back-to-back matches.
    step(1, 0, 0, 0);
    force u0.match_count = 16'hFFFE;
    e_mc[0] = 16'hFFFE;
    step(0, 0, 0, 0);
    release u0.match_count;
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 1);
    check("c0_saturate", 32'(mc_o[0]), 32'hFFFF);
    step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
